// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs memory stage, MEM priority,
// IF starvation guard, MEM lock for multi-word accesses, one-cycle read return.
module mem_arbiter #(
  parameter int unsigned WORD_LENGTH   = 16,
  parameter int unsigned ADDRESS_SPACE = 12,
  parameter int unsigned STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDRESS_SPACE-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [WORD_LENGTH-1:0]   if_rdata,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic                     mem_lock,
  input  logic [ADDRESS_SPACE-1:0] mem_addr,
  input  logic [WORD_LENGTH-1:0]   mem_wdata,
  output logic                     mem_gnt,
  output logic                     mem_rvalid,
  output logic [WORD_LENGTH-1:0]   mem_rdata,
  output logic                     m_en,
  output logic                     m_rw,
  output logic [ADDRESS_SPACE-1:0] m_addr,
  output logic [WORD_LENGTH-1:0]   m_wdata,
  input  logic [WORD_LENGTH-1:0]   m_rdata
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWN_MEM = 2'd1;
  localparam logic [1:0] OWN_IF  = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  logic [1:0]             state, state_nxt;
  logic [SW-1:0]          starve_cnt, starve_nxt;
  logic                   forced;
  logic                   if_pend, mem_pend;
  logic [WORD_LENGTH-1:0] if_hold, mem_hold;

  assign forced = (starve_cnt == SW'(STARVE_LIMIT));

  // State, starvation counter, pending-read flags and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_pend    <= 1'b0;
      mem_pend   <= 1'b0;
      if_hold    <= '0;
      mem_hold   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if_pend    <= if_gnt;
      mem_pend   <= mem_gnt & ~mem_we;
      if (if_pend)  if_hold  <= m_rdata;
      if (mem_pend) mem_hold <= m_rdata;
    end
  end

  // Grant decision, next owner, starvation update and memory-side mux
  always_comb begin
    if_gnt     = 1'b0;
    mem_gnt    = 1'b0;
    state_nxt  = IDLE;
    starve_nxt = '0;
    m_rw       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    if (!reset) begin
      if (state == LOCKED) begin
        mem_gnt = mem_req;
      end else if (if_req && mem_req) begin
        if (forced) if_gnt  = 1'b1;
        else        mem_gnt = 1'b1;
      end else begin
        if_gnt  = if_req;
        mem_gnt = mem_req;
      end

      if (mem_gnt)     state_nxt = mem_lock ? LOCKED : OWN_MEM;
      else if (if_gnt) state_nxt = OWN_IF;

      if (if_req && !if_gnt) starve_nxt = forced ? starve_cnt : starve_cnt + SW'(1);

      if (if_gnt) begin
        m_rw   = 1'b1;
        m_addr = if_addr;
      end else if (mem_gnt) begin
        m_rw    = ~mem_we;
        m_addr  = mem_addr;
        m_wdata = mem_wdata;
      end
    end
    m_en = if_gnt | mem_gnt;
  end

  // Read data returns in the cycle after the grant; a reset cancels it
  assign if_rvalid  = if_pend & ~reset;
  assign mem_rvalid = mem_pend & ~reset;
  assign if_rdata   = reset ? '0 : (if_pend ? m_rdata : if_hold);
  assign mem_rdata  = reset ? '0 : (mem_pend ? m_rdata : mem_hold);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16: data word width.
REQ-002 SHALL have parameter ADDRESS_SPACE, default 12: address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3: consecutive denied IF cycles before IF is forced.
REQ-004 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port if_req  in  1: instruction-fetch read request.
REQ-007 SHALL have port if_addr  in  ADDRESS_SPACE: fetch address.
REQ-008 SHALL have port if_gnt  out  1: fetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid  out  1: fetch read data valid.
REQ-010 SHALL have port if_rdata  out  WORD_LENGTH: fetch read data.
REQ-011 SHALL have port mem_req  in  1: memory-stage request.
REQ-012 SHALL have port mem_we  in  1: 1 = write, 0 = read.
REQ-013 SHALL have port mem_lock  in  1: hold ownership for multi-word access (e.g. 32-bit PC push/pop).
REQ-014 SHALL have port mem_addr  in  ADDRESS_SPACE: memory-stage address.
REQ-015 SHALL have port mem_wdata  in  WORD_LENGTH: memory-stage write data.
REQ-016 SHALL have port mem_gnt  out  1: memory-stage request accepted this cycle.
REQ-017 SHALL have port mem_rvalid  out  1: memory-stage read data valid.
REQ-018 SHALL have port mem_rdata  out  WORD_LENGTH: memory-stage read data.
REQ-019 SHALL have ports m_en, m_rw (1 = read, 0 = write)  out  1 each: memory enable and direction.
REQ-020 SHALL have ports m_addr  out  ADDRESS_SPACE and m_wdata  out  WORD_LENGTH: memory address and write data.
REQ-021 SHALL have port m_rdata  in  WORD_LENGTH: memory read data, valid one cycle after a read is sampled.

Function
REQ-022 SHALL grant at most one requester per cycle; if_gnt and mem_gnt are combinational from requests and registered state.
REQ-023 SHALL drive m_en = if_gnt | mem_gnt; m_rw = 1 for an IF grant, ~mem_we for a MEM grant; m_addr and m_wdata come from the granted requester, and are 0 when neither is granted.
REQ-024 SHALL use owner FSM states IDLE, OWN_MEM, OWN_IF, LOCKED, recording the owner of the previous cycle's grant.
REQ-025 SHALL give MEM priority over IF when both request and starve_cnt < STARVE_LIMIT.
REQ-026 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle if_req=1 and if_gnt=0, and clear it on an IF grant or when if_req=0.
REQ-027 SHALL grant IF over MEM when starve_cnt == STARVE_LIMIT, unless state is LOCKED.
REQ-028 SHALL enter LOCKED when mem_gnt=1 with mem_lock=1; in LOCKED only MEM is granted, and IF is denied even when forced.
REQ-029 SHALL leave LOCKED on the first cycle with mem_req=1 and mem_lock=0 (that access is granted, next state OWN_MEM), or on mem_req=0 (next state IDLE).
REQ-030 SHALL assert the owner's rvalid exactly one cycle after a granted read, with rdata = m_rdata in that cycle.
REQ-031 SHALL hold rdata at its last value and rvalid at 0 otherwise; writes SHALL produce no rvalid.
REQ-032 SHALL sustain back-to-back grants with no bubble (throughput one access per cycle).

Reset
REQ-033 SHALL, while reset=1, force if_gnt=mem_gnt=m_en=0, m_rw=0, m_addr=m_wdata=0 regardless of requests.
REQ-034 SHALL set state=IDLE, starve_cnt=0, if_rvalid=mem_rvalid=0, if_rdata=mem_rdata=0 on reset.
REQ-035 SHALL drop a read issued in the cycle before reset asserts (no rvalid after reset).
REQ-036 SHALL release LOCKED on reset.

Verification
REQ-037 SHALL cover: if_req=1, if_addr=0x010, m_rdata=0xBEEF next cycle -> if_gnt=1 at cycle N; if_rvalid=1 with if_rdata=0xBEEF at N+1.
REQ-038 SHALL cover: both request every cycle, STARVE_LIMIT=3 -> grant pattern MEM, MEM, MEM, IF, repeating.
REQ-039 SHALL cover: mem_we=1, mem_addr=0x020, mem_wdata=0x1234 -> m_en=1, m_rw=0, m_addr=0x020, m_wdata=0x1234; mem_rvalid stays 0.
REQ-040 SHALL cover: mem_lock=1 for 5 cycles with if_req=1 -> if_gnt=0 throughout; first cycle after unlock with starve_cnt saturated -> if_gnt=1.
REQ-041 SHALL cover: reset=1 in the cycle after an IF read grant -> if_rvalid=0, all grants 0, state IDLE, starve_cnt 0.
REQ-042 SHALL cover: no requests -> m_en=0, m_addr=0, both rvalid 0 for 10 cycles.
